interpolation_sequencer: RTL and testbench

Cycle sequencer that sits directly upstream of the fractional-motion-estimation interpolation controller. It produces the three phase-completion strobes `PH_INTERPOLATION_finished`, `PVPO_INTERPOLATION_finished` and `PVSO_INTERPOLATION_finished` that advance the controller, and drives the reference-sample read port during the horizontal pass. It runs its own shadow copy of the controller's phase sequence from the same `enable`, so both FSMs change phase on the same clock edges.

---
 rtl/interpolation_sequencer.sv | 121 ++++++++++++
 tb/tb_interpolation_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interpolation_sequencer.sv
// interpolation_sequencer: shadow phase sequencer for the FME
// interpolation controller, with phase strobes and sample read port.
module interpolation_sequencer #(
   parameter int PH_CYCLES   = 16,
   parameter int PVPO_CYCLES = 7,
   parameter int PVSO_CYCLES = 27,
   parameter int ADDR_WIDTH  = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   output logic                  PH_INTERPOLATION_finished,
   output logic                  PVPO_INTERPOLATION_finished,
   output logic                  PVSO_INTERPOLATION_finished,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            block_count
);

   typedef enum logic [2:0] {
      IDLE,
      BEGINNING,
      PH,
      SETUP,
      PVPO,
      PVSO
   } state_t;

   localparam logic [4:0] PH_LAST   = 5'(PH_CYCLES - 1);
   localparam logic [4:0] PVPO_LAST = 5'(PVPO_CYCLES - 1);
   localparam logic [4:0] PVSO_LAST = 5'(PVSO_CYCLES - 1);

   state_t     state;
   logic [4:0] cnt;
   logic       ph_fin;
   logic       pvpo_fin;
   logic       pvso_fin;

   assign ph_fin   = (state == PH)   && (cnt == PH_LAST);
   assign pvpo_fin = (state == PVPO) && (cnt == PVPO_LAST);
   assign pvso_fin = (state == PVSO) && (cnt == PVSO_LAST);

   assign PH_INTERPOLATION_finished   = ph_fin;
   assign PVPO_INTERPOLATION_finished = pvpo_fin;
   assign PVSO_INTERPOLATION_finished = pvso_fin;

   assign rd_en = (state == BEGINNING) || (state == PH);
   assign busy  = (state != IDLE);

   // Phase FSM; cnt restarts at zero on every state change.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (enable) state <= BEGINNING;
            end
            BEGINNING: begin
               cnt   <= '0;
               state <= PH;
            end
            PH: begin
               if (ph_fin) begin
                  cnt   <= '0;
                  state <= SETUP;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            SETUP: begin
               cnt   <= '0;
               state <= PVPO;
            end
            PVPO: begin
               if (pvpo_fin) begin
                  cnt   <= '0;
                  state <= PVSO;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            PVSO: begin
               if (pvso_fin) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Read address, completion pulse and block counter.
   // rd_addr is cleared on the closing edge too so IDLE always shows row 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr     <= '0;
         done        <= 1'b0;
         block_count <= 8'd0;
      end else begin
         done <= pvso_fin;
         if (pvso_fin) block_count <= block_count + 8'd1;
         if ((state == IDLE) || pvso_fin) begin
            rd_addr <= '0;
         end else if (rd_en) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_interpolation_sequencer.sv
// tb_interpolation_sequencer: table vectors, corner sequences and
// random enables checked against a position-based reference model.
module tb_interpolation_sequencer;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic enable_a = 1'b0;
   logic enable_b = 1'b0;

   logic       ph_a, pv_a, ps_a, rden_a, busy_a, done_a;
   logic [4:0] addr_a;
   logic [7:0] bc_a;
   logic       ph_b, pv_b, ps_b, rden_b, busy_b, done_b;
   logic [4:0] addr_b;
   logic [7:0] bc_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   interpolation_sequencer dut_a (
      .clock(clock), .reset_n(reset_n), .enable(enable_a),
      .PH_INTERPOLATION_finished(ph_a),
      .PVPO_INTERPOLATION_finished(pv_a),
      .PVSO_INTERPOLATION_finished(ps_a),
      .rd_en(rden_a), .rd_addr(addr_a), .busy(busy_a),
      .done(done_a), .block_count(bc_a)
   );

   interpolation_sequencer #(
      .PH_CYCLES(1), .PVPO_CYCLES(1), .PVSO_CYCLES(31), .ADDR_WIDTH(5)
   ) dut_b (
      .clock(clock), .reset_n(reset_n), .enable(enable_b),
      .PH_INTERPOLATION_finished(ph_b),
      .PVPO_INTERPOLATION_finished(pv_b),
      .PVSO_INTERPOLATION_finished(ps_b),
      .rd_en(rden_b), .rd_addr(addr_b), .busy(busy_b),
      .done(done_b), .block_count(bc_b)
   );

   logic [18:0] pack_a, pack_b;
   assign pack_a = {ph_a, pv_a, ps_a, rden_a, busy_a, done_a, addr_a, bc_a};
   assign pack_b = {ph_b, pv_b, ps_b, rden_b, busy_b, done_b, addr_b, bc_b};

   // Model: p = cycle position inside a block (0 = idle).
   typedef struct {
      int p;
      bit dn;
      int bc;
   } mdl_t;

   mdl_t ma = '{0, 0, 0};
   mdl_t mb = '{0, 0, 0};

   localparam int LA = 1 + 16 + 1 + 7 + 27;
   localparam int LB = 1 + 1 + 1 + 1 + 31;

   function automatic mdl_t step(mdl_t m, logic en, int len);
      mdl_t r = m;
      r.dn = 0;
      if (m.p == 0) begin
         if (en) r.p = 1;
      end else if (m.p == len) begin
         r.p = 0;
         r.dn = 1;
         r.bc = (m.bc + 1) % 256;
      end else begin
         r.p = m.p + 1;
      end
      return r;
   endfunction

   function automatic logic [18:0] expv(mdl_t m, int ph, int pv, int ps);
      int len = 1 + ph + 1 + pv + ps;
      logic s_ph, s_pv, s_ps, re, bz;
      int a;
      s_ph = (m.p == ph + 1);
      s_pv = (m.p == ph + 2 + pv);
      s_ps = (m.p == len);
      re = (m.p >= 1) && (m.p <= ph + 1);
      bz = (m.p > 0);
      if (m.p == 0) a = 0;
      else if (m.p <= ph + 1) a = m.p - 1;
      else a = ph + 1;
      return {s_ph, s_pv, s_ps, re, bz, m.dn, 5'(a), 8'(m.bc)};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model advances on the same edges as the DUTs.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ma <= '{0, 0, 0};
         mb <= '{0, 0, 0};
      end else begin
         ma <= step(ma, enable_a, LA);
         mb <= step(mb, enable_b, LB);
      end
   end

   // Continuous model comparison, away from the active edge.
   always @(negedge clock) begin
      chk("model_a", 32'(pack_a), 32'(expv(ma, 16, 7, 27)));
      chk("model_b", 32'(pack_b), 32'(expv(mb, 1, 1, 31)));
   end

   typedef struct {
      int         cyc;
      logic [5:0] fl;
      int         addr;
      int         bc;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int busy_n, strb_n, starts, dn_n, k;
      int st[3];
      int c_ph, c_pv, c_ps, c_dn;
      logic pb;

      // flags: {ph, pvpo, pvso, rd_en, busy, done}
      tbl[0]  = '{1,  6'b000110, 0,  0};
      tbl[1]  = '{2,  6'b000110, 1,  0};
      tbl[2]  = '{16, 6'b000110, 15, 0};
      tbl[3]  = '{17, 6'b100110, 16, 0};
      tbl[4]  = '{18, 6'b000010, 17, 0};
      tbl[5]  = '{24, 6'b000010, 17, 0};
      tbl[6]  = '{25, 6'b010010, 17, 0};
      tbl[7]  = '{26, 6'b000010, 17, 0};
      tbl[8]  = '{51, 6'b000010, 17, 0};
      tbl[9]  = '{52, 6'b001010, 17, 0};
      tbl[10] = '{53, 6'b000001, 0,  1};
      tbl[11] = '{54, 6'b000000, 0,  1};

      repeat (3) @(negedge clock);
      chk("reset_a", 32'(pack_a), 32'd0);
      chk("reset_b", 32'(pack_b), 32'd0);
      #2 reset_n = 1'b1;

      // Single block, table-driven.
      @(negedge clock);
      enable_a = 1'b1;
      busy_n = 0;
      strb_n = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clock);
         if (c == 1) enable_a = 1'b0;
         busy_n += int'(busy_a);
         strb_n += int'(ph_a) + int'(pv_a) + int'(ps_a);
         foreach (tbl[i]) begin
            if (tbl[i].cyc == c) begin
               chk($sformatf("tbl_c%0d", c), 32'(pack_a),
                   32'({tbl[i].fl, 5'(tbl[i].addr), 8'(tbl[i].bc)}));
            end
         end
      end
      chk("busy_cycles", busy_n, 52);
      chk("strobe_cycles", strb_n, 3);

      // Asynchronous reset in PVPO.
      enable_a = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         if (c == 1) enable_a = 1'b0;
      end
      chk("pre_rst_busy", 32'(busy_a), 32'd1);
      #2 reset_n = 1'b0;
      #1 chk("async_rst", 32'(pack_a), 32'd0);
      @(negedge clock);
      #2 reset_n = 1'b1;
      dn_n = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         dn_n += int'(done_a) + int'(busy_a);
      end
      chk("post_rst_quiet", dn_n, 0);
      chk("post_rst_bc", 32'(bc_a), 32'd0);

      // Back-to-back blocks with enable held.
      enable_a = 1'b1;
      starts = 0;
      pb = 1'b0;
      for (int c = 1; c <= 170; c++) begin
         @(negedge clock);
         if (c == 150) enable_a = 1'b0;
         if (busy_a && !pb) begin
            if (starts < 3) st[starts] = c;
            starts++;
         end
         pb = busy_a;
         if (c == 158) chk("b2b_bc_158", 32'(bc_a), 32'd2);
         if (c == 159) chk("b2b_bc_159", 32'(bc_a), 32'd3);
      end
      chk("b2b_starts", starts, 3);
      chk("b2b_start0", st[0], 1);
      chk("b2b_start1", st[1], 54);
      chk("b2b_start2", st[2], 107);

      // Boundary phase lengths on instance b.
      enable_b = 1'b1;
      c_ph = 0; c_pv = 0; c_ps = 0; c_dn = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         if (c == 1) enable_b = 1'b0;
         if (ph_b) c_ph = c_ph * 100 + c;
         if (pv_b) c_pv = c_pv * 100 + c;
         if (ps_b) c_ps = c_ps * 100 + c;
         if (done_b) c_dn = c_dn * 100 + c;
      end
      chk("bnd_ph", c_ph, 2);
      chk("bnd_pvpo", c_pv, 4);
      chk("bnd_pvso", c_ps, 35);
      chk("bnd_done", c_dn, 36);

      // block_count wrap after 256 blocks.
      @(negedge clock);
      #2 reset_n = 1'b0;
      @(negedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
      enable_b = 1'b1;
      k = 0;
      for (int c = 0; c < 256 * 36 + 100 && k < 256; c++) begin
         @(negedge clock);
         if (done_b) begin
            k++;
            if (k == 255) chk("wrap_255", 32'(bc_b), 32'd255);
            if (k == 256) chk("wrap_0", 32'(bc_b), 32'd0);
         end
      end
      chk("wrap_blocks", k, 256);
      enable_b = 1'b0;
      repeat (40) @(negedge clock);

      // Random enables with occasional asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         enable_a = ($urandom % 8) == 0;
         enable_b = ($urandom % 6) == 0;
         if (($urandom % 400) == 0) begin
            #2 reset_n = 1'b0;
            @(negedge clock);
            #2 reset_n = 1'b1;
         end
      end
      enable_a = 1'b0;
      enable_b = 1'b0;
      @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
